// File: rtl/ysyx_23060184_axil_sram.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : ysyx_23060184_axil_sram                                          |
// | Brief   : AXI4-Lite subordinate over an on-chip word array; independent    |
// |           read/write FSMs, programmable latency, strobe-masked writes,     |
// |           DECERR outside the window. Optional macro: SRAM_RAND_DELAY_EN.   |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
module ysyx_23060184_axil_sram #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           RD_LAT     = 1,
  parameter int unsigned           WR_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned WMASK_LENGTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W        = $clog2(DEPTH);
  localparam int unsigned CNT_W        = 16;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_DECERR  = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_e;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0] rd_load;
  logic [CNT_W-1:0] wr_load;

`ifdef SRAM_RAND_DELAY_EN
  // Fibonacci LFSR, taps 8,6,5,4: adds 0..3 cycles to every loaded count.
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign rd_load = CNT_W'(RD_LAT) + CNT_W'(lfsr_q[1:0]);
  assign wr_load = CNT_W'(WR_LAT) + CNT_W'(lfsr_q[1:0]);
`else
  assign rd_load = CNT_W'(RD_LAT);
  assign wr_load = CNT_W'(WR_LAT);
`endif

  // ---------------------------------------------------------------- read side
  rstate_e               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs, r_load, r_hit;
  logic [ADDR_WIDTH-1:0] r_addr_eff;
  logic [IDX_W-1:0]      r_idx;

  always_comb begin
    rstate_d   = rstate_q;
    raddr_d    = raddr_q;
    rcnt_d     = rcnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    r_load     = 1'b0;
    ar_hs      = arvalid && (rstate_q == R_IDLE);
    // Zero-latency reads sample the array with the address still on the bus.
    r_addr_eff = ar_hs ? araddr : raddr_q;
    r_hit      = addr_hit(r_addr_eff);
    r_idx      = addr_idx(r_addr_eff);
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d = araddr;
          if (rd_load == '0) begin
            r_load = 1'b1;
          end else begin
            rcnt_d   = rd_load;
            rstate_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rcnt_q <= CNT_W'(1)) r_load = 1'b1;
        else                     rcnt_d = rcnt_q - CNT_W'(1);
      end
      R_RESP: begin
        if (rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
    if (r_load) begin
      rstate_d = R_RESP;
      rdata_d  = r_hit ? mem_q[r_idx] : '0;
      rresp_d  = r_hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rcnt_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rcnt_q   <= rcnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // --------------------------------------------------------------- write side
  wstate_e                 wstate_q, wstate_d;
  logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WMASK_LENGTH-1:0] wstrb_q, wstrb_d;
  logic [CNT_W-1:0]        wcnt_q, wcnt_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    aw_hs, w_hs, w_commit, w_hit;
  logic [ADDR_WIDTH-1:0]   waddr_eff;
  logic [DATA_WIDTH-1:0]   wdata_eff;
  logic [WMASK_LENGTH-1:0] wstrb_eff;
  logic [IDX_W-1:0]        w_idx;

  always_comb begin
    wstate_d  = wstate_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    aw_hs     = awvalid && (wstate_q == W_IDLE) && !aw_got_q;
    w_hs      = wvalid  && (wstate_q == W_IDLE) && !w_got_q;
    if (aw_hs) awaddr_d = awaddr;
    if (w_hs) begin
      wdata_d = wdata;
      wstrb_d = wstrb;
    end
    waddr_eff = aw_hs ? awaddr : awaddr_q;
    wdata_eff = w_hs  ? wdata  : wdata_q;
    wstrb_eff = w_hs  ? wstrb  : wstrb_q;
    w_hit     = addr_hit(waddr_eff);
    w_idx     = addr_idx(waddr_eff);
    case (wstate_q)
      W_IDLE: begin
        aw_got_d = aw_got_q || aw_hs;
        w_got_d  = w_got_q  || w_hs;
        if (aw_got_d && w_got_d) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          if (wr_load == '0) begin
            w_commit = 1'b1;
          end else begin
            wcnt_d   = wr_load;
            wstate_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (wcnt_q <= CNT_W'(1)) w_commit = 1'b1;
        else                     wcnt_d = wcnt_q - CNT_W'(1);
      end
      W_RESP: begin
        if (bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    if (w_commit) begin
      wstate_d = W_RESP;
      bresp_d  = w_hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt_q   <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
    end
  end

  // Array is never cleared; a commit racing a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_hit) begin
      for (int k = 0; k < WMASK_LENGTH; k++) begin
        if (wstrb_eff[k]) mem_q[w_idx][8*k +: 8] <= wdata_eff[8*k +: 8];
      end
    end
  end

  assign arready = !reset && (rstate_q == R_IDLE);
  assign rvalid  = !reset && (rstate_q == R_RESP);
  assign rdata   = reset ? '0 : rdata_q;
  assign rresp   = reset ? RESP_OKAY : rresp_q;
  assign awready = !reset && (wstate_q == W_IDLE) && !aw_got_q;
  assign wready  = !reset && (wstate_q == W_IDLE) && !w_got_q;
  assign bvalid  = !reset && (wstate_q == W_RESP);
  assign bresp   = reset ? RESP_OKAY : bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_axil_sram.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_ysyx_23060184_axil_sram                                       |
// | Brief   : Vector table, corner sequences and randomized traffic against a  |
// |           word-array reference model for the AXI4-Lite SRAM.               |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_ysyx_23060184_axil_sram;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          DEPTH_T  = 1024;
  localparam int          RD_LAT_T = 1;
  localparam int          WR_LAT_T = 1;

  logic clk, reset;
  // main instance
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  // shared inputs for the latency-0 and latency-3 instances
  logic [31:0] x_araddr, x_awaddr, x_wdata;
  logic        x_arvalid, x_rready, x_awvalid, x_wvalid, x_bready;
  logic [3:0]  x_wstrb;
  logic [31:0] d0_rdata, d3_rdata;
  logic [1:0]  d0_rresp, d3_rresp, d0_bresp, d3_bresp;
  logic        d0_arready, d0_rvalid, d0_awready, d0_wready, d0_bvalid;
  logic        d3_arready, d3_rvalid, d3_awready, d3_wready, d3_bvalid;

  ysyx_23060184_axil_sram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH_T), .BASE_ADDR(BASE),
                            .RD_LAT(RD_LAT_T), .WR_LAT(WR_LAT_T)) dut (
    .clk(clk), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready));

  ysyx_23060184_axil_sram #(.DEPTH(DEPTH_T), .BASE_ADDR(BASE), .RD_LAT(0), .WR_LAT(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .araddr(x_araddr), .arvalid(x_arvalid), .arready(d0_arready),
    .rdata(d0_rdata), .rresp(d0_rresp), .rvalid(d0_rvalid), .rready(x_rready),
    .awaddr(x_awaddr), .awvalid(x_awvalid), .awready(d0_awready),
    .wdata(x_wdata), .wstrb(x_wstrb), .wvalid(x_wvalid), .wready(d0_wready),
    .bresp(d0_bresp), .bvalid(d0_bvalid), .bready(x_bready));

  ysyx_23060184_axil_sram #(.DEPTH(DEPTH_T), .BASE_ADDR(BASE), .RD_LAT(3), .WR_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .araddr(x_araddr), .arvalid(x_arvalid), .arready(d3_arready),
    .rdata(d3_rdata), .rresp(d3_rresp), .rvalid(d3_rvalid), .rready(x_rready),
    .awaddr(x_awaddr), .awvalid(x_awvalid), .awready(d3_awready),
    .wdata(x_wdata), .wstrb(x_wstrb), .wvalid(x_wvalid), .wready(d3_wready),
    .bresp(d3_bresp), .bvalid(d3_bvalid), .bready(x_bready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain word array plus address-window arithmetic.
  logic [31:0] model_mem [DEPTH_T];

  function automatic bit ref_hit(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH_T);
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] lo;
    r  = $urandom_range(0, 9);
    lo = 32'($urandom_range(0, 3));
    if (r < 4) return BASE + 32'($urandom_range(0, 15)) * 4 + lo;
    if (r < 8) return BASE + 32'($urandom_range(1008, 1023)) * 4 + lo;
    if (r == 8) return BASE + 32'(4 * DEPTH_T) + 32'($urandom_range(0, 255)) * 4;
    return BASE - 32'($urandom_range(1, 256)) * 4;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_wait,
                          input logic [1:0] exp_resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc, lat;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done  && (cyc >= w_dly);
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
      if (w_done && !aw_done) check("w_only_wready_low", {wready, bvalid}, 2'b00);
      if (aw_done && !w_done) check("aw_only_awready_low", {awready, bvalid}, 2'b00);
    end
    awvalid = 0; wvalid = 0;
    check("w_handshake", {aw_done, w_done}, 2'b11);
    lat = 1;
    while (!bvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b_latency", lat, WR_LAT_T + 1);
    check("bresp", bresp, exp_resp);
    for (int i = 0; i < b_wait; i++) begin
      @(posedge clk); #1;
      check("b_hold", {bvalid, bresp}, {1'b1, exp_resp});
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("b_done", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_wait,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit done, hs;
    int cyc, lat;
    done = 0; cyc = 0;
    araddr = a;
    while (!done && cyc < 40) begin
      arvalid = (cyc >= ar_dly);
      hs      = arvalid && arready;
      @(posedge clk); #1;
      done = hs;
      cyc++;
    end
    arvalid = 0;
    check("ar_handshake", done, 1);
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("r_latency", lat, RD_LAT_T + 1);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int i = 0; i < r_wait; i++) begin
      @(posedge clk); #1;
      check("r_hold", {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("r_done", {rvalid, arready}, 2'b01);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  initial begin
    vec_t vecs[10];
    logic [31:0] a, d;
    logic [3:0]  s;
    int idx, b0, b3, r0, r3, n0, n3, bad0, bad3;

    vecs[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h8000_0010, 32'h0000_AB00, 4'h2, 2'b00, 32'hDEAD_ABEF, 2'b00};
    vecs[2] = '{32'h8000_0010, 32'h1234_5678, 4'h0, 2'b00, 32'hDEAD_ABEF, 2'b00};
    vecs[3] = '{32'h8000_1000, 32'h1111_1111, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
    vecs[4] = '{32'h8000_0FFF, 32'hCAFE_F00D, 4'hF, 2'b00, 32'hCAFE_F00D, 2'b00};
    vecs[5] = '{32'h7FFF_FFFC, 32'h2222_2222, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
    vecs[6] = '{32'h8000_0000, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 2'b00};
    vecs[7] = '{32'h8000_0002, 32'hA1B2_C3D4, 4'h9, 2'b00, 32'hA100_00D4, 2'b00};
    vecs[8] = '{32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
    vecs[9] = '{32'h8000_0000, 32'h5555_5555, 4'h0, 2'b00, 32'hA100_00D4, 2'b00};

    reset = 1;
    araddr = 0; arvalid = 0; rready = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0;
    wvalid = 0; bready = 0;
    x_araddr = 0; x_arvalid = 0; x_rready = 0; x_awaddr = 0; x_awvalid = 0; x_wdata = 0;
    x_wstrb = 0; x_wvalid = 0; x_bready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero",
          {arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}, 64'd0);
    reset = 0;
    #1;
    check("post_reset_ready", {arready, awready, wready, rvalid, bvalid}, 5'b11100);

    foreach (vecs[i]) begin
      do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0, 1, vecs[i].bresp);
      do_read(vecs[i].addr, 0, 2, vecs[i].rdata, vecs[i].rresp);
    end

    // W three cycles ahead of AW, then AW ahead of W.
    do_write(BASE + 32'h30, 32'h7766_5544, 4'hF, 3, 0, 2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b_single_pulse", bvalid, 0);
    end
    do_read(BASE + 32'h30, 0, 0, 32'h7766_5544, 2'b00);
    do_write(BASE + 32'h34, 32'h0102_0304, 4'hC, 0, 2, 0, 2'b00);
    do_write(BASE + 32'h34, 32'hFFFF_EEDD, 4'h3, 0, 0, 0, 2'b00);
    do_read(BASE + 32'h34, 1, 1, 32'h0102_EEDD, 2'b00);

    // Reset while write sits in W_RESP and read sits in R_WAIT.
    awaddr = BASE + 32'h40; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    check("rst_pre_bvalid", bvalid, 1);
    araddr = BASE + 32'h10; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    check("rst_pre_rwait", {arready, rvalid}, 2'b00);
    reset = 1;
    #1;
    check("rst_outputs_zero", {arready, awready, wready, rvalid, bvalid}, 5'b00000);
    @(posedge clk); #1;
    reset = 0;
    #1;
    check("rst_recovered", {rvalid, bvalid, arready, awready, wready}, 5'b00111);
    do_read(BASE + 32'h40, 0, 0, 32'h0BAD_F00D, 2'b00);
    do_read(BASE + 32'h10, 0, 0, 32'hDEAD_ABEF, 2'b00);

    // Latency-0 and latency-3 instances side by side.
    x_awaddr = BASE + 32'h20; x_wdata = 32'h5A5A_1234; x_wstrb = 4'hF; x_bready = 1;
    x_awvalid = 1; x_wvalid = 1;
    @(posedge clk); #1;
    x_awvalid = 0; x_wvalid = 0;
    b0 = 0; b3 = 0;
    for (int c = 1; c <= 8; c++) begin
      if (d0_bvalid && b0 == 0) b0 = c;
      if (d3_bvalid && b3 == 0) b3 = c;
      @(posedge clk); #1;
    end
    check("l0_b_latency", b0, 1);
    check("l3_b_latency", b3, 4);
    x_bready = 0;
    x_araddr = BASE + 32'h20; x_rready = 0; x_arvalid = 1;
    @(posedge clk); #1;
    x_arvalid = 0;
    r0 = 0; r3 = 0; n0 = 0; n3 = 0; bad0 = 0; bad3 = 0;
    for (int c = 1; c <= 10; c++) begin
      if (d0_rvalid) begin
        if (r0 == 0) r0 = c;
        n0++;
        if (d0_rdata !== 32'h5A5A_1234 || d0_rresp !== 2'b00) bad0++;
      end
      if (d3_rvalid) begin
        if (r3 == 0) r3 = c;
        n3++;
        if (d3_rdata !== 32'h5A5A_1234 || d3_rresp !== 2'b00) bad3++;
      end
      @(posedge clk); #1;
    end
    check("l0_r_latency", r0, 1);
    check("l3_r_latency", r3, 4);
    check("l0_rvalid_held", n0, 10);
    check("l3_rvalid_held", n3, 7);
    check("l0_rdata_stable", bad0, 0);
    check("l3_rdata_stable", bad3, 0);
    x_rready = 1;
    @(posedge clk); #1;
    x_rready = 0;
    check("lx_r_done", {d0_rvalid, d3_rvalid, d0_arready, d3_arready}, 4'b0011);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 32; i++) begin
      idx = (i < 16) ? i : 992 + i;
      d   = $urandom;
      do_write(BASE + 32'(idx) * 4, d, 4'hF, 0, 0, 0, 2'b00);
      model_mem[idx] = d;
    end
    for (int n = 0; n < 150; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 ref_hit(a) ? 2'b00 : 2'b11);
        if (ref_hit(a)) begin
          idx = ref_idx(a);
          for (int k = 0; k < 4; k++) if (s[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
        end
      end else begin
        if (ref_hit(a)) do_read(a, $urandom_range(0, 3), $urandom_range(0, 3),
                                model_mem[ref_idx(a)], 2'b00);
        else            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), 32'h0, 2'b11);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
